ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the ID_EX register outputs and resolves operands through EX/MEM and MEM/WB forwarding.
- Computes the single-cycle ALU result and owns the HI/LO registers, fed by an iterative 32-cycle multiply/divide engine.
- Drives `ex_stall` to the hazard unit, which deasserts ID_EX `en_reg` while a mult/div is in flight.

Parameters:
- `MD_CYCLES`, 32, number of iteration cycles for mult/div (one bit per cycle).

Ports:
- `clk`  in  1  pipeline clock
- `rst`  in  1  asynchronous, active-high reset
- `instr_valid`  in  1  EX holds a real instruction (0 after flush or reset)
- `ALUOp`  in  2  00 = add, 01 = sub (beq), 10 = R-type by funct
- `ALUSrc`  in  1  1 = operand B is `extend_immed`
- `RegDst`  in  1  1 = dest is rd, 0 = dest is rt
- `funct`  in  6  R-type function field
- `rs`, `rt`, `rd`  in  5 each  register numbers
- `rfile_rd1`, `rfile_rd2`  in  32 each  register-file read data
- `extend_immed`  in  32  sign-extended immediate
- `exmem_RegWrite`  in  1  EX/MEM write-enable
- `exmem_rd`  in  5  EX/MEM destination
- `exmem_result`  in  32  EX/MEM ALU result
- `memwb_RegWrite`  in  1  MEM/WB write-enable
- `memwb_rd`  in  5  MEM/WB destination
- `memwb_wdata`  in  32  MEM/WB writeback data
- `alu_result`  out  32  combinational EX result
- `store_data`  out  32  forwarded rt value for sw
- `write_reg`  out  5  selected destination register
- `zero`  out  1  `alu_result == 0`
- `ex_stall`  out  1  hold IF/ID and ID_EX
- `hi_out`, `lo_out`  out  32 each  HI/LO register contents

Behaviour:
- Forwarding, A side (same rule for B with `rt`):
  - If `exmem_RegWrite` and `exmem_rd != 0` and `exmem_rd == rs`, select `exmem_result`.
  - Else if `memwb_RegWrite` and `memwb_rd != 0` and `memwb_rd == rs`, select `memwb_wdata`.
  - Else select `rfile_rd1`.
  - EX/MEM wins when both match.
- Operands: `store_data` = forwarded B. Operand B = `extend_immed` if `ALUSrc`, else forwarded B. `write_reg` = `RegDst` ? `rd` : `rt`.
- ALU result:
  - `ALUOp` 00 gives A+B; 01 gives A-B; both wrap modulo 2^32.
  - `ALUOp` 10 decodes funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0 or 1), 0x10 mfhi, 0x12 mflo.
  - Any other funct, and any funct when `instr_valid` = 0, gives 0.
- Start condition: `instr_valid` and `ALUOp` = 10 and funct in {0x18 mult, 0x19 multu, 0x1A div, 0x1B divu}, with state IDLE. At the start edge the engine latches the forwarded A and B.
- FSM states are IDLE, BUSY, DONE:
  - IDLE→BUSY on start, count loads `MD_CYCLES`-1.
  - BUSY decrements count each cycle. At count 0 the next edge writes HI/LO and enters DONE.
  - DONE→IDLE unconditionally. Start is suppressed in DONE, because the same mult is still in ID_EX.
- `ex_stall` is combinational: 1 when (IDLE and start) or BUSY; 0 in DONE. A start at cycle T stalls T..T+32; the pipeline advances at T+33.
- Multiply uses shift-add on magnitudes; the signed variant negates the 64-bit product if the operand signs differ. HI = product[63:32], LO = product[31:0].
- Divide uses restoring division on magnitudes:
  - Signed: quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - LO = quotient, HI = remainder.
  - -2^31 / -1 gives LO = 0x80000000, HI = 0.
- Divide by zero: IDLE→DONE directly, skipping BUSY, with HI = A and LO = 0xFFFFFFFF; stall lasts 1 cycle.
- mfhi/mflo in the cycle after DONE see the new HI/LO values.
- Reset: asynchronous. State = IDLE, count = 0, HI = LO = 0, internal accumulators = 0, `ex_stall` = 0 while `rst` is high. Reset mid-BUSY aborts the operation with no HI/LO update.

Optional Feature:
- Macro `EX_MULDIV_EN`.
- Defined: HI/LO, the FSM and the muldiv engine are present as described above.
- Undefined: no HI/LO state and no FSM. `ex_stall` is tied to 0; `hi_out` and `lo_out` are tied to 0; funct 0x10, 0x12 and 0x18–0x1B give `alu_result` 0 with no stall.

Decomposition:
- Shared package `ex_pkg`:
  - ALUOp codes
  - funct constants
  - FSM state encoding
  - forwarding-select encoding (RF / EXMEM / MEMWB)
- Sub-module `muldiv_unit`: FSM, counter, iteration datapath, sign fixup, HI/LO registers. `ex_stage` keeps forwarding, the ALU and the dest mux.

Test Plan:
- ALU and forwarding: `rs` = 3, `exmem_rd` = 3 with result 0x10, `memwb_rd` = 3 with wdata 0x20, rd2 = 5, add → `alu_result` 0x15 (EX/MEM priority); clear `exmem_RegWrite` → 0x25; `exmem_rd` = 0 → ignored.
- slt and beq: A = 0xFFFFFFFF, B = 1, slt → 1. `ALUOp` 01 with A = B = 7 → `zero` = 1.
- mult: A = -3, B = 7 (signed) → `ex_stall` high for exactly 33 cycles from the start cycle; then mfhi = 0xFFFFFFFF, mflo = 0xFFFFFFEB. multu 0xFFFFFFFF × 2 → HI = 1, LO = 0xFFFFFFFE.
- div: A = -7, B = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu 100/0 → stall 1 cycle, HI = 100, LO = 0xFFFFFFFF.
- Reset mid-operation: assert `rst` at BUSY count 10 → `ex_stall` = 0 immediately, HI/LO = 0, next mult starts cleanly.
- `instr_valid` = 0 with funct = mult → no stall, `alu_result` 0. Build without `EX_MULDIV_EN` → mult never stalls.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp codes, funct values,
// mult/div FSM states and operand forwarding selects.
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
  typedef enum logic [1:0] {FWD_RF, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;

  // The younger EX/MEM producer takes priority over MEM/WB; $zero never forwards.
  function automatic fwd_sel_e fwd_select(input logic exmem_we, input logic [4:0] exmem_rd,
                                          input logic memwb_we, input logic [4:0] memwb_rd,
                                          input logic [4:0] src);
    if (exmem_we && exmem_rd != 5'd0 && exmem_rd == src) return FWD_EXMEM;
    if (memwb_we && memwb_rd != 5'd0 && memwb_rd == src) return FWD_MEMWB;
    return FWD_RF;
  endfunction

  // mult, multu, div, divu occupy funct 0x18..0x1B
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative mult/div engine (one bit per cycle) owning HI/LO.
// op_i = funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu.
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);
  localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        div_q, div_d, neg_q, neg_d, rneg_q, rneg_d;

  logic        sa, sb;
  logic [31:0] mag_a, mag_b, step_hi, step_lo;
  logic [32:0] msum, dshift;
  logic [33:0] ddiff;
  logic [63:0] prod;

  assign sa    = ~op_i[0] & a_i[31];
  assign sb    = ~op_i[0] & b_i[31];
  assign mag_a = sa ? -a_i : a_i;
  assign mag_b = sb ? -b_i : b_i;

  // Mult: {acc_hi,acc_lo} shifts right with conditional add of the multiplicand.
  // Div: restoring step, acc_hi = partial remainder, acc_lo = dividend -> quotient.
  assign msum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? b_q : 32'd0)};
  assign dshift = {acc_hi_q, acc_lo_q[31]};
  assign ddiff  = {1'b0, dshift} - {2'b00, b_q};

  always_comb begin
    if (div_q) begin
      step_hi = ddiff[33] ? dshift[31:0] : ddiff[31:0];
      step_lo = {acc_lo_q[30:0], ~ddiff[33]};
    end else begin
      step_hi = msum[32:1];
      step_lo = {msum[0], acc_lo_q[31:1]};
    end
  end

  assign prod    = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign stall_o = ~rst & ((state_q == MD_IDLE && start_i) || state_q == MD_BUSY);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    b_d      = b_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      MD_IDLE: if (start_i) begin
        if (op_i[1] && b_i == 32'd0) begin
          state_d = MD_DONE;
          hi_d    = a_i;
          lo_d    = 32'hFFFF_FFFF;
        end else begin
          state_d  = MD_BUSY;
          cnt_d    = CW'(MD_CYCLES - 1);
          acc_hi_d = '0;
          acc_lo_d = mag_a;
          b_d      = mag_b;
          div_d    = op_i[1];
          neg_d    = sa ^ sb;
          rneg_d   = sa;
        end
      end
      MD_BUSY: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = MD_DONE;
          if (div_q) begin
            hi_d = rneg_q ? -step_hi : step_hi;
            lo_d = neg_q ? -step_lo : step_lo;
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
        end
      end
      // The finished instruction is still in ID_EX here, so no restart.
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      b_q      <= b_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: forwarding, ALU, dest mux; HI/LO and the mult/div
// engine exist only when EX_MULDIV_EN is defined.
module ex_stage
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [1:0]  ALUOp,
  input  logic        ALUSrc,
  input  logic        RegDst,
  input  logic [5:0]  funct,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] rfile_rd1,
  input  logic [31:0] rfile_rd2,
  input  logic [31:0] extend_immed,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_wdata,
  output logic [31:0] alu_result,
  output logic [31:0] store_data,
  output logic [4:0]  write_reg,
  output logic        zero,
  output logic        ex_stall,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  fwd_sel_e    sel_a, sel_b;
  logic [31:0] op_a, fwd_b, op_b, hi_w, lo_w;
  logic        md_start;

  assign sel_a = fwd_select(exmem_RegWrite, exmem_rd, memwb_RegWrite, memwb_rd, rs);
  assign sel_b = fwd_select(exmem_RegWrite, exmem_rd, memwb_RegWrite, memwb_rd, rt);

  always_comb begin
    case (sel_a)
      FWD_EXMEM: op_a = exmem_result;
      FWD_MEMWB: op_a = memwb_wdata;
      default:   op_a = rfile_rd1;
    endcase
    case (sel_b)
      FWD_EXMEM: fwd_b = exmem_result;
      FWD_MEMWB: fwd_b = memwb_wdata;
      default:   fwd_b = rfile_rd2;
    endcase
  end

  assign op_b       = ALUSrc ? extend_immed : fwd_b;
  assign store_data = fwd_b;
  assign write_reg  = RegDst ? rd : rt;
  assign md_start   = instr_valid && ALUOp == ALUOP_RTYPE && is_muldiv(funct);

  always_comb begin
    alu_result = '0;
    case (ALUOp)
      ALUOP_ADD: alu_result = op_a + op_b;
      ALUOP_SUB: alu_result = op_a - op_b;
      ALUOP_RTYPE: if (instr_valid) begin
        case (funct)
          F_ADD:   alu_result = op_a + op_b;
          F_SUB:   alu_result = op_a - op_b;
          F_AND:   alu_result = op_a & op_b;
          F_OR:    alu_result = op_a | op_b;
          F_SLT:   alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
          F_MFHI:  alu_result = hi_w;
          F_MFLO:  alu_result = lo_w;
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign zero   = (alu_result == 32'd0);
  assign hi_out = hi_w;
  assign lo_out = lo_w;

`ifdef EX_MULDIV_EN
  muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .op_i    (funct[1:0]),
    .a_i     (op_a),
    .b_i     (fwd_b),
    .stall_o (ex_stall),
    .hi_o    (hi_w),
    .lo_o    (lo_w)
  );
`else
  logic unused_md;
  assign unused_md = ^{clk, rst, md_start};
  assign ex_stall  = 1'b0;
  assign hi_w      = '0;
  assign lo_w      = '0;
`endif

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of combinational ALU/forwarding vectors,
// then hand-written mult/div and reset sequences (EX_MULDIV_EN selects which).
module tb_ex_stage;
  logic        clk, rst, instr_valid, ALUSrc, RegDst;
  logic [1:0]  ALUOp;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd, exmem_rd, memwb_rd, write_reg;
  logic [31:0] rfile_rd1, rfile_rd2, extend_immed, exmem_result, memwb_wdata;
  logic        exmem_RegWrite, memwb_RegWrite, zero, ex_stall;
  logic [31:0] alu_result, store_data, hi_out, lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage #(.MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .ALUOp(ALUOp), .ALUSrc(ALUSrc),
    .RegDst(RegDst), .funct(funct), .rs(rs), .rt(rt), .rd(rd),
    .rfile_rd1(rfile_rd1), .rfile_rd2(rfile_rd2), .extend_immed(extend_immed),
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .alu_result(alu_result), .store_data(store_data), .write_reg(write_reg), .zero(zero),
    .ex_stall(ex_stall), .hi_out(hi_out), .lo_out(lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluop;
    logic        src, dst, valid;
    logic [5:0]  fn;
    logic [4:0]  s, t, d;
    logic [31:0] r1, r2, imm;
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        mww;
    logic [4:0]  mwrd;
    logic [31:0] mwdat;
    logic [31:0] e_res, e_st;
    logic [4:0]  e_wr;
    logic        e_zero;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] aluop, input logic src, dst, valid,
                              input logic [5:0] fn, input logic [4:0] s, t, d,
                              input logic [31:0] r1, r2, imm,
                              input logic exw, input logic [4:0] exrd, input logic [31:0] exres,
                              input logic mww, input logic [4:0] mwrd, input logic [31:0] mwdat,
                              input logic [31:0] e_res, e_st, input logic [4:0] e_wr,
                              input logic e_zero);
    vec_t v;
    v.aluop = aluop; v.src = src; v.dst = dst; v.valid = valid; v.fn = fn;
    v.s = s; v.t = t; v.d = d; v.r1 = r1; v.r2 = r2; v.imm = imm;
    v.exw = exw; v.exrd = exrd; v.exres = exres;
    v.mww = mww; v.mwrd = mwrd; v.mwdat = mwdat;
    v.e_res = e_res; v.e_st = e_st; v.e_wr = e_wr; v.e_zero = e_zero;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    instr_valid = 1'b0; ALUOp = 2'b00; ALUSrc = 1'b0; RegDst = 1'b0; funct = 6'h00;
    rs = 5'd0; rt = 5'd0; rd = 5'd0; rfile_rd1 = '0; rfile_rd2 = '0; extend_immed = '0;
    exmem_RegWrite = 1'b0; exmem_rd = 5'd0; exmem_result = '0;
    memwb_RegWrite = 1'b0; memwb_rd = 5'd0; memwb_wdata = '0;
  endtask

  task automatic drive_rtype(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    drive_idle();
    instr_valid = 1'b1; ALUOp = 2'b10; RegDst = 1'b1; funct = f;
    rs = 5'd1; rt = 5'd2; rd = 5'd3; rfile_rd1 = a; rfile_rd2 = b;
  endtask

  // Start an op, count stalled cycles (bounded), then read HI/LO via mfhi/mflo.
  task automatic run_md(input string nm, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    @(negedge clk);
    drive_rtype(f, a, b);
    #1;
    n = 0;
    while (ex_stall && n < 200) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({nm, " stall cycles"}, 32'(n), 32'(exp_stall));
    @(negedge clk);
    drive_rtype(6'h10, 32'd0, 32'd0);
    #1;
    check({nm, " mfhi"}, alu_result, ehi);
    funct = 6'h12;
    #1;
    check({nm, " mflo"}, alu_result, elo);
    check({nm, " hi_out"}, hi_out, ehi);
    check({nm, " lo_out"}, lo_out, elo);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = mk(2'b10,0,1,1,6'h20, 3,4,7, 32'h99,32'h5,0,       1,3,32'h10, 1,3,32'h20, 32'h15,32'h5,7,0);
    vecs[1]  = mk(2'b10,0,1,1,6'h20, 3,4,7, 32'h99,32'h5,0,       0,3,32'h10, 1,3,32'h20, 32'h25,32'h5,7,0);
    vecs[2]  = mk(2'b10,0,1,1,6'h20, 0,4,7, 32'h0,32'h5,0,        1,0,32'h10, 1,3,32'h20, 32'h5,32'h5,7,0);
    vecs[3]  = mk(2'b10,0,1,1,6'h2A, 1,2,8, 32'hFFFFFFFF,32'h1,0, 0,0,0, 0,0,0, 32'h1,32'h1,8,0);
    vecs[4]  = mk(2'b01,0,0,1,6'h00, 1,2,8, 32'h7,32'h7,0,        0,0,0, 0,0,0, 32'h0,32'h7,2,1);
    vecs[5]  = mk(2'b00,1,0,1,6'h00, 1,9,8, 32'd10,32'h1234,32'hFFFFFFFC, 0,0,0, 0,0,0, 32'd6,32'h1234,9,0);
    vecs[6]  = mk(2'b10,0,1,1,6'h24, 1,5,10, 32'hF0F0,32'h0,0,    0,0,0, 1,5,32'hFF00, 32'hF000,32'hFF00,10,0);
    vecs[7]  = mk(2'b10,0,1,1,6'h25, 1,5,10, 32'hF0F0,32'h0,0,    0,0,0, 1,5,32'hFF00, 32'hFFF0,32'hFF00,10,0);
    vecs[8]  = mk(2'b10,0,1,1,6'h22, 1,2,3, 32'h1,32'h2,0,        0,0,0, 0,0,0, 32'hFFFFFFFF,32'h2,3,0);
    vecs[9]  = mk(2'b10,0,1,1,6'h27, 1,2,3, 32'h3,32'h4,0,        0,0,0, 0,0,0, 32'h0,32'h4,3,1);
    vecs[10] = mk(2'b10,0,1,0,6'h20, 1,2,3, 32'h3,32'h4,0,        0,0,0, 0,0,0, 32'h0,32'h4,3,1);
    vecs[11] = mk(2'b10,0,1,0,6'h18, 1,2,3, 32'h3,32'h4,0,        0,0,0, 0,0,0, 32'h0,32'h4,3,1);
    vecs[12] = mk(2'b10,0,1,1,6'h20, 1,6,3, 32'd10,32'd100,0,     1,6,32'h3, 1,6,32'h9, 32'hD,32'h3,3,0);

    drive_idle();
    rst = 1'b1;
    #2;
    check("reset ex_stall", {31'd0, ex_stall}, 32'd0);
    check("reset hi_out", hi_out, 32'd0);
    check("reset lo_out", lo_out, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ALUOp = vecs[i].aluop; ALUSrc = vecs[i].src; RegDst = vecs[i].dst;
      instr_valid = vecs[i].valid; funct = vecs[i].fn;
      rs = vecs[i].s; rt = vecs[i].t; rd = vecs[i].d;
      rfile_rd1 = vecs[i].r1; rfile_rd2 = vecs[i].r2; extend_immed = vecs[i].imm;
      exmem_RegWrite = vecs[i].exw; exmem_rd = vecs[i].exrd; exmem_result = vecs[i].exres;
      memwb_RegWrite = vecs[i].mww; memwb_rd = vecs[i].mwrd; memwb_wdata = vecs[i].mwdat;
      #1;
      check($sformatf("vec%0d alu_result", i), alu_result, vecs[i].e_res);
      check($sformatf("vec%0d store_data", i), store_data, vecs[i].e_st);
      check($sformatf("vec%0d write_reg", i), {27'd0, write_reg}, {27'd0, vecs[i].e_wr});
      check($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].e_zero});
      check($sformatf("vec%0d ex_stall", i), {31'd0, ex_stall}, 32'd0);
    end

`ifdef EX_MULDIV_EN
    run_md("mult -3*7", 6'h18, 32'hFFFFFFFD, 32'd7, 33, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run_md("multu ffffffff*2", 6'h19, 32'hFFFFFFFF, 32'd2, 33, 32'h1, 32'hFFFFFFFE);
    run_md("div -7/2", 6'h1A, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("divu 100/0", 6'h1B, 32'd100, 32'd0, 1, 32'd100, 32'hFFFFFFFF);
    run_md("div min/-1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 33, 32'h0, 32'h80000000);
    run_md("divu 100/7", 6'h1B, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    // Abort mid-BUSY: 22 cycles after start the counter reads 10.
    @(negedge clk);
    drive_rtype(6'h18, 32'd5, 32'd6);
    repeat (22) @(negedge clk);
    #1;
    check("mid-op ex_stall before reset", {31'd0, ex_stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid-op reset ex_stall", {31'd0, ex_stall}, 32'd0);
    check("mid-op reset hi_out", hi_out, 32'd0);
    check("mid-op reset lo_out", lo_out, 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    run_md("mult 5*6 after reset", 6'h18, 32'd5, 32'd6, 33, 32'd0, 32'd30);
`else
    @(negedge clk);
    drive_rtype(6'h18, 32'hFFFFFFFD, 32'd7);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("nomd mult stall c%0d", c), {31'd0, ex_stall}, 32'd0);
      check($sformatf("nomd mult result c%0d", c), alu_result, 32'd0);
      @(negedge clk);
    end
    funct = 6'h10;
    #1;
    check("nomd mfhi", alu_result, 32'd0);
    check("nomd hi_out", hi_out, 32'd0);
    funct = 6'h12;
    #1;
    check("nomd mflo", alu_result, 32'd0);
    check("nomd lo_out", lo_out, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
